// File: rtl/queue_pkg.sv
// Shared definitions for the 1-bit queue/stack family: default depth,
// pointer-width helper and the push/pop action encoding.
package queue_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;

    // Width of a pointer that addresses 'depth' entries (at least 1 bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Accepted-action encoding: {push_accepted, pop_accepted}.
    typedef enum logic [1:0] {
        ACT_NONE = 2'b00,
        ACT_POP  = 2'b01,
        ACT_PUSH = 2'b10,
        ACT_BOTH = 2'b11
    } act_e;

endpackage

// File: rtl/bit_queue_wrap_ptr.sv
// Module wrap_ptr: PTR_W-bit pointer with synchronous active-high reset and
// increment enable, wrapping from DEPTH-1 back to 0.
module wrap_ptr
    import queue_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: advance on enable, wrap at the last slot.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/bit_queue.sv
// bit_queue: 1-bit first-word-fall-through FIFO with occupancy, full/empty
// status and registered overflow/underflow pulses. Same data/push/pop/D_out
// interface as the 1-bit LIFO stack.
// Optional build macro BIT_QUEUE_WATERMARK_EN adds AF_LEVEL/AE_LEVEL
// parameters and registered almost_full/almost_empty outputs.
module bit_queue
    import queue_pkg::*;
#(
    parameter  int unsigned DEPTH    = DEPTH_DEFAULT,
`ifdef BIT_QUEUE_WATERMARK_EN
    parameter  int unsigned AF_LEVEL = DEPTH - 2,
    parameter  int unsigned AE_LEVEL = 1,
`endif
    localparam int unsigned PTR_W    = ptr_w(DEPTH)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           data,
    input  logic           push,
    input  logic           pop,
    output logic           D_out,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count,
`ifdef BIT_QUEUE_WATERMARK_EN
    output logic           almost_full,
    output logic           almost_empty,
`endif
    output logic           overflow,
    output logic           underflow
);

    localparam int unsigned    CNT_W    = PTR_W + 1;
    localparam logic [PTR_W:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0] mem_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
`ifdef BIT_QUEUE_WATERMARK_EN
    localparam logic [PTR_W:0] AF_CNT = CNT_W'(AF_LEVEL);
    localparam logic [PTR_W:0] AE_CNT = CNT_W'(AE_LEVEL);
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
`endif

    logic             push_ok;
    logic             pop_ok;
    act_e             act;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Acceptance: a pop frees a slot, so a push into a full queue is taken
    // when it is paired with an accepted pop.
    always_comb begin
        pop_ok  = pop & ~empty_q;
        push_ok = push & (~full_q | pop_ok);
        act     = act_e'({push_ok, pop_ok});
    end

    wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (CLK),
        .rst (RST),
        .inc (push_ok),
        .ptr (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (CLK),
        .rst (RST),
        .inc (pop_ok),
        .ptr (rd_ptr)
    );

    // Next-state occupancy, status flags and error pulses.
    always_comb begin
        count_d = count_q;
        unique case (act)
            ACT_PUSH: count_d = count_q + CNT_W'(1);
            ACT_POP:  count_d = count_q - CNT_W'(1);
            default:  count_d = count_q;
        endcase
        full_d      = (count_d == FULL_CNT);
        empty_d     = (count_d == '0);
        overflow_d  = push & ~push_ok;
        underflow_d = pop & ~pop_ok;
`ifdef BIT_QUEUE_WATERMARK_EN
        almost_full_d  = (count_d >= AF_CNT);
        almost_empty_d = (count_d <= AE_CNT);
`endif
    end

    // Storage write on accepted push; contents are not reset.
    always_comb begin
        mem_d = mem_q;
        if (push_ok && !RST) begin
            mem_d[wr_ptr] = data;
        end
    end

    // Status registers; reset discards any concurrent push/pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef BIT_QUEUE_WATERMARK_EN
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
`endif
        end else begin
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef BIT_QUEUE_WATERMARK_EN
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
`endif
        end
    end

    // Storage register.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign D_out     = empty_q ? 1'b0 : mem_q[rd_ptr];
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`ifdef BIT_QUEUE_WATERMARK_EN
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_bit_queue.sv
// Directed self-checking bench for bit_queue (default build, DEPTH=8).
module tb_bit_queue;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       data = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       D_out;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int unsigned checks = 0;
    int unsigned failures = 0;

    bit_queue #(.DEPTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .data      (data),
        .push      (push),
        .pop       (pop),
        .D_out     (D_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic cycle(input logic p, input logic q, input logic d, input logic r);
        push = p;
        pop  = q;
        data = d;
        RST  = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [3:0] c, input logic e,
                                input logic f, input logic ov, input logic un);
        check_eq({tag, ".count"}, 32'(count), 32'(c));
        check_eq({tag, ".empty"}, 32'(empty), 32'(e));
        check_eq({tag, ".full"}, 32'(full), 32'(f));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(ov));
        check_eq({tag, ".udf"}, 32'(underflow), 32'(un));
    endtask

    logic [3:0] seq_a;

    initial begin
        // Reset, then idle 3 cycles.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        check_status("reset", 4'd0, 1, 0, 0, 0);
        check_eq("reset.dout", 32'(D_out), 32'd0);

        // Push 1,0,1,1 then pop 4 times.
        seq_a = 4'b1101; // bit i is the i-th pushed value
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, seq_a[i], 0);
            check_eq($sformatf("fill4.count%0d", i), 32'(count), 32'(i + 1));
        end
        check_eq("fill4.head", 32'(D_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain4.dout%0d", i), 32'(D_out), 32'(seq_a[i]));
            cycle(0, 1, 0, 0);
            check_eq($sformatf("drain4.count%0d", i), 32'(count), 32'(3 - i));
        end
        check_status("drain4", 4'd0, 1, 0, 0, 0);
        check_eq("drain4.dout", 32'(D_out), 32'd0);

        // Fill to 8 with alternating 1/0 (pointers start at 4 and wrap).
        for (int i = 0; i < 8; i++) cycle(1, 0, (i % 2 == 0), 0);
        check_status("fill8", 4'd8, 0, 1, 0, 0);
        cycle(1, 0, 1, 0);
        check_status("ovf", 4'd8, 0, 1, 1, 0);
        check_eq("ovf.head", 32'(D_out), 32'd1);
        cycle(0, 0, 0, 0);
        check_eq("ovf.clear", 32'(overflow), 32'd0);

        // Full queue: push+pop with data=0 for 8 cycles.
        for (int k = 1; k <= 8; k++) begin
            cycle(1, 1, 0, 0);
            check_eq($sformatf("both%0d.count", k), 32'(count), 32'd8);
            check_eq($sformatf("both%0d.full", k), 32'(full), 32'd1);
            check_eq($sformatf("both%0d.ovf", k), 32'(overflow), 32'd0);
            check_eq($sformatf("both%0d.dout", k), 32'(D_out), (k < 8) ? 32'(k % 2 == 0) : 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("drain0s.dout%0d", i), 32'(D_out), 32'd0);
            cycle(0, 1, 0, 0);
        end
        check_status("drain0s", 4'd0, 1, 0, 0, 0);

        // Pop while empty -> single-cycle underflow.
        cycle(0, 1, 0, 0);
        check_status("udf", 4'd0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check_eq("udf.clear", 32'(underflow), 32'd0);

        // Push+pop on empty: push taken, pop rejected.
        cycle(1, 1, 1, 0);
        check_status("pp_empty", 4'd1, 0, 0, 0, 1);
        check_eq("pp_empty.dout", 32'(D_out), 32'd1);
        cycle(0, 1, 0, 0);
        check_status("pp_empty.pop", 4'd0, 1, 0, 0, 0);

        // Push 5 bits, then reset with push asserted.
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0);
        check_eq("pre_rst.count", 32'(count), 32'd5);
        cycle(1, 0, 1, 1);
        check_status("mid_rst", 4'd0, 1, 0, 0, 0);
        check_eq("mid_rst.dout", 32'(D_out), 32'd0);
        cycle(1, 0, 1, 0);
        check_status("post_rst", 4'd1, 0, 0, 0, 0);
        check_eq("post_rst.dout", 32'(D_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_queue.md
Name: bit_queue

Overview:
- 1-bit-wide FIFO queue.
- The first-in-first-out counterpart of the team's 1-bit LIFO stack.
- Uses the same data/push/pop/D_out interface, so a producer can swap ordering discipline without re-wiring.
- Adds occupancy, full/empty status and overflow/underflow reporting that the stack lacks.

Parameters:
- DEPTH, 8, number of 1-bit entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- CLK  input  1  register clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- data  input  1  bit to enqueue when push accepted.
- push  input  1  enqueue request, sampled each rising edge.
- pop  input  1  dequeue request, sampled each rising edge.
- D_out  output  1  head-of-queue bit (first-word-fall-through).
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: push rejected.
- underflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST; RST has priority over push/pop in the same cycle.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, D_out=0, overflow=0, underflow=0. Storage contents are don't-care after reset.
- push accepted iff push=1 and (full=0 or pop is accepted in the same cycle). Accepted push writes data to mem[wr_ptr]; wr_ptr advances by 1 modulo DEPTH.
- pop accepted iff pop=1 and empty=0. Accepted pop advances rd_ptr by 1 modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- full and empty are registered, derived from the next-state count; they are valid the cycle after the edge that changes count.
- D_out:
  - Equals mem[rd_ptr] when empty=0, and 0 when empty=1.
  - Combinational from registered state, so there is no extra read latency.
  - A bit pushed into an empty queue at edge N appears on D_out immediately after edge N.
- Push while full, no pop: data dropped, no state change, overflow=1 for the following cycle.
- Pop while empty: no state change, underflow=1 for the following cycle.
- Simultaneous push+pop:
  - Empty: push accepted, pop rejected, underflow pulses, count becomes 1.
  - Full: both accepted, count stays DEPTH, full stays 1; the new bit lands in the slot just vacated.
  - Otherwise: both accepted, count unchanged.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- overflow and underflow are registered, cleared every cycle unless re-asserted, and forced 0 by RST.
- RST mid-stream: the queue empties on that edge; any concurrent push/pop is discarded with no overflow/underflow pulse.

Optional Feature:
- Macro: BIT_QUEUE_WATERMARK_EN.
- Defined:
  - Adds parameters AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 1).
  - Adds registered outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL).
  - Reset values: almost_full=0, almost_empty=1.
- Not defined: neither port nor parameters exist; all other behaviour is identical.

Decomposition:
- Shared package queue_pkg:
  - DEPTH_DEFAULT=8.
  - A clog2-based pointer-width helper.
  - An enum for push/pop action (ACT_NONE, ACT_PUSH, ACT_POP, ACT_BOTH), shared with the stack's future checker.
- One natural sub-module, wrap_ptr:
  - A PTR_W-bit counter with synchronous reset and an increment enable, wrapping modulo DEPTH.
  - Instantiated twice (write and read pointer).

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, D_out=0, no pulses.
- Push 1,0,1,1 then pop 4 times -> D_out reads 1,0,1,1 in order; count 4->0; empty=1 after last pop.
- Fill to 8 with alternating 1/0, then push one more -> full=1, count=8, overflow pulses 1 cycle, head still 1.
- Empty queue, pop -> underflow pulses 1 cycle. Push+pop with data=1 -> underflow pulses, count=1, D_out=1.
- Full queue, push+pop with data=0 for 8 cycles -> count stays 8, full stays 1; output sequence is the original 8 bits, then the 0s; pointers wrap cleanly.
- Push 5 bits, assert RST with push=1 -> count=0, empty=1, no overflow; the next push of 1 gives D_out=1, count=1.
